// File: rtl/id_stage_hz.sv
// Decode stage with register file, immediate extension, opcode decoder, RAW/load-use hazard
// detection and an ID/EX pipeline register with freeze, flush and bubble insertion.
module id_stage_hz #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 32,
  parameter int unsigned IMM_W   = 16,
  parameter bit          FWD_EN  = 1'b1,
  localparam int unsigned RA_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en_wb,
  input  logic [RA_W-1:0]   dest_wb,
  input  logic [DATA_W-1:0] result_wb,
  input  logic              exe_wb_en,
  input  logic              exe_mem_rd,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dest,
  output logic              hazard_stall,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] reg2_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [RA_W-1:0]   dest_out,
  output logic [RA_W-1:0]   src1_out,
  output logic [RA_W-1:0]   src2_out,
  output logic              wb_en_out,
  output logic [1:0]        mem_sig_out,
  output logic [1:0]        br_type_out,
  output logic [3:0]        exe_cmd_out
);

  localparam logic [5:0] OpAdd  = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000011;
  localparam logic [5:0] OpAnd  = 6'b000101;
  localparam logic [5:0] OpOr   = 6'b000110;
  localparam logic [5:0] OpNor  = 6'b000111;
  localparam logic [5:0] OpXor  = 6'b001000;
  localparam logic [5:0] OpSla  = 6'b001001;
  localparam logic [5:0] OpSll  = 6'b001010;
  localparam logic [5:0] OpSra  = 6'b001011;
  localparam logic [5:0] OpSrl  = 6'b001100;
  localparam logic [5:0] OpAddi = 6'b100000;
  localparam logic [5:0] OpSubi = 6'b100001;
  localparam logic [5:0] OpLd   = 6'b100100;
  localparam logic [5:0] OpSt   = 6'b100101;
  localparam logic [5:0] OpBez  = 6'b101000;
  localparam logic [5:0] OpBne  = 6'b101001;
  localparam logic [5:0] OpJmp  = 6'b101010;

  typedef struct packed {
    logic       wb;
    logic [1:0] mem;
    logic [1:0] br;
    logic [3:0] cmd;
    logic       is_imm;
    logic       use_src1;
    logic       use_src2;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] pc;
    logic [RA_W-1:0]   dest;
    logic [RA_W-1:0]   src1;
    logic [RA_W-1:0]   src2;
    logic              wb;
    logic [1:0]        mem;
    logic [1:0]        br;
    logic [3:0]        cmd;
  } idex_t;

  logic [5:0]        op;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rt;
  logic [RA_W-1:0]   rd;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;

  assign op      = instruction[31:26];
  assign rs      = instruction[21 +: RA_W];
  assign rt      = instruction[16 +: RA_W];
  assign rd      = instruction[11 +: RA_W];
  assign imm     = instruction[IMM_W-1:0];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  // Opcode decoder; anything unlisted behaves as NOP and uses no sources.
  ctrl_t ctrl;

  always_comb begin
    ctrl          = '0;
    ctrl.use_src1 = 1'b1;
    case (op)
      OpAdd:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0000; ctrl.use_src2 = 1'b1; end
      OpSub:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0010; ctrl.use_src2 = 1'b1; end
      OpAnd:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0100; ctrl.use_src2 = 1'b1; end
      OpOr:   begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0101; ctrl.use_src2 = 1'b1; end
      OpNor:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0110; ctrl.use_src2 = 1'b1; end
      OpXor:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0111; ctrl.use_src2 = 1'b1; end
      OpSla,
      OpSll:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b1000; ctrl.use_src2 = 1'b1; end
      OpSra:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b1001; ctrl.use_src2 = 1'b1; end
      OpSrl:  begin ctrl.wb = 1'b1; ctrl.cmd = 4'b1010; ctrl.use_src2 = 1'b1; end
      OpAddi: begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0000; ctrl.is_imm = 1'b1; end
      OpSubi: begin ctrl.wb = 1'b1; ctrl.cmd = 4'b0010; ctrl.is_imm = 1'b1; end
      OpLd: begin
        ctrl.wb     = 1'b1;
        ctrl.mem    = 2'b10;
        ctrl.is_imm = 1'b1;
      end
      OpSt: begin
        ctrl.mem      = 2'b01;
        ctrl.is_imm   = 1'b1;
        ctrl.use_src2 = 1'b1;
      end
      OpBez:  begin ctrl.br = 2'b01; ctrl.is_imm = 1'b1; end
      OpBne:  begin ctrl.br = 2'b10; ctrl.is_imm = 1'b1; ctrl.use_src2 = 1'b1; end
      OpJmp:  begin ctrl.br = 2'b11; ctrl.is_imm = 1'b1; ctrl.use_src1 = 1'b0; end
      default: ctrl.use_src1 = 1'b0;
    endcase
  end

  // Register file; entry 0 is never written so it stays zero.
  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic              rf_we;

  assign rf_we = wb_en_wb && (dest_wb != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[dest_wb] <= result_wb;
    end
  end

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Write-through so an instruction decoded alongside its producer's writeback sees the new value.
  always_comb begin
    rs_data = rf_q[rs];
    if (rs == '0) begin
      rs_data = '0;
    end else if (rf_we && (dest_wb == rs)) begin
      rs_data = result_wb;
    end
  end

  always_comb begin
    rt_data = rf_q[rt];
    if (rt == '0) begin
      rt_data = '0;
    end else if (rf_we && (dest_wb == rt)) begin
      rt_data = result_wb;
    end
  end

  // With forwarding only an in-flight load in EX is unresolvable; without it any producer
  // in EX or MEM blocks the instruction.
  logic exe_blocks;
  logic mem_blocks;
  logic rs_hit;
  logic rt_hit;

  assign exe_blocks = FWD_EN ? (exe_wb_en && exe_mem_rd) : exe_wb_en;
  assign mem_blocks = FWD_EN ? 1'b0 : mem_wb_en;

  assign rs_hit = ctrl.use_src1 && (rs != '0) &&
                  ((exe_blocks && (exe_dest == rs)) || (mem_blocks && (mem_dest == rs)));
  assign rt_hit = ctrl.use_src2 && (rt != '0) &&
                  ((exe_blocks && (exe_dest == rt)) || (mem_blocks && (mem_dest == rt)));

  assign hazard_stall = (rs_hit || rt_hit) && !flush;

  // ID/EX pipeline register.
  idex_t idex_q;
  idex_t idex_d;
  idex_t idex_dec;

  always_comb begin
    idex_dec      = '0;
    idex_dec.val1 = rs_data;
    idex_dec.val2 = ctrl.is_imm ? imm_ext : rt_data;
    idex_dec.reg2 = rt_data;
    idex_dec.pc   = pc_in;
    idex_dec.dest = ctrl.is_imm ? rt : rd;
    idex_dec.src1 = rs;
    idex_dec.src2 = rt;
    idex_dec.wb   = ctrl.wb;
    idex_dec.mem  = ctrl.mem;
    idex_dec.br   = ctrl.br;
    idex_dec.cmd  = ctrl.cmd;
  end

  always_comb begin
    idex_d = idex_q;
    if (!freeze) begin
      if (flush || hazard_stall) begin
        idex_d = '0;
      end else begin
        idex_d = idex_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign val1        = idex_q.val1;
  assign val2        = idex_q.val2;
  assign reg2_out    = idex_q.reg2;
  assign pc_out      = idex_q.pc;
  assign dest_out    = idex_q.dest;
  assign src1_out    = idex_q.src1;
  assign src2_out    = idex_q.src2;
  assign wb_en_out   = idex_q.wb;
  assign mem_sig_out = idex_q.mem;
  assign br_type_out = idex_q.br;
  assign exe_cmd_out = idex_q.cmd;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: two instances (forwarding on/off) on shared inputs, checked by a
// hazard vector table, directed sequences and a randomized run against a reference model.
module tb_id_stage_hz;

  localparam logic [5:0] OpNop  = 6'b000000;
  localparam logic [5:0] OpAdd  = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000011;
  localparam logic [5:0] OpAnd  = 6'b000101;
  localparam logic [5:0] OpOr   = 6'b000110;
  localparam logic [5:0] OpNor  = 6'b000111;
  localparam logic [5:0] OpXor  = 6'b001000;
  localparam logic [5:0] OpSla  = 6'b001001;
  localparam logic [5:0] OpSll  = 6'b001010;
  localparam logic [5:0] OpSra  = 6'b001011;
  localparam logic [5:0] OpSrl  = 6'b001100;
  localparam logic [5:0] OpAddi = 6'b100000;
  localparam logic [5:0] OpSubi = 6'b100001;
  localparam logic [5:0] OpLd   = 6'b100100;
  localparam logic [5:0] OpSt   = 6'b100101;
  localparam logic [5:0] OpBez  = 6'b101000;
  localparam logic [5:0] OpBne  = 6'b101001;
  localparam logic [5:0] OpJmp  = 6'b101010;

  logic        clk = 1'b0;
  logic        rst, flush, freeze;
  logic [31:0] instruction, pc_in, result_wb;
  logic        wb_en_wb, exe_wb_en, exe_mem_rd, mem_wb_en;
  logic [4:0]  dest_wb, exe_dest, mem_dest;

  logic        o1_hazard, o0_hazard;
  logic [31:0] o1_val1, o1_val2, o1_reg2, o1_pc, o0_val1, o0_val2, o0_reg2, o0_pc;
  logic [4:0]  o1_dest, o1_src1, o1_src2, o0_dest, o0_src1, o0_src2;
  logic        o1_wb, o0_wb;
  logic [1:0]  o1_mem, o1_br, o0_mem, o0_br;
  logic [3:0]  o1_cmd, o0_cmd;

  always #5 clk = ~clk;

  id_stage_hz #(.FWD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .instruction(instruction),
    .pc_in(pc_in), .wb_en_wb(wb_en_wb), .dest_wb(dest_wb), .result_wb(result_wb),
    .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard_stall(o1_hazard),
    .val1(o1_val1), .val2(o1_val2), .reg2_out(o1_reg2), .pc_out(o1_pc),
    .dest_out(o1_dest), .src1_out(o1_src1), .src2_out(o1_src2), .wb_en_out(o1_wb),
    .mem_sig_out(o1_mem), .br_type_out(o1_br), .exe_cmd_out(o1_cmd)
  );

  id_stage_hz #(.FWD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .instruction(instruction),
    .pc_in(pc_in), .wb_en_wb(wb_en_wb), .dest_wb(dest_wb), .result_wb(result_wb),
    .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard_stall(o0_hazard),
    .val1(o0_val1), .val2(o0_val2), .reg2_out(o0_reg2), .pc_out(o0_pc),
    .dest_out(o0_dest), .src1_out(o0_src1), .src2_out(o0_src2), .wb_en_out(o0_wb),
    .mem_sig_out(o0_mem), .br_type_out(o0_br), .exe_cmd_out(o0_cmd)
  );

  typedef struct packed {
    logic [31:0] val1, val2, reg2, pc;
    logic [4:0]  dest, src1, src2;
    logic        wb;
    logic [1:0]  mem, br;
    logic [3:0]  cmd;
  } out_t;

  out_t act1, act0;
  assign act1 = {o1_val1, o1_val2, o1_reg2, o1_pc, o1_dest, o1_src1, o1_src2,
                 o1_wb, o1_mem, o1_br, o1_cmd};
  assign act0 = {o0_val1, o0_val2, o0_reg2, o0_pc, o0_dest, o0_src1, o0_src2,
                 o0_wb, o0_mem, o0_br, o0_cmd};

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".val1"}, a.val1, e.val1);
    chk({tag, ".val2"}, a.val2, e.val2);
    chk({tag, ".reg2"}, a.reg2, e.reg2);
    chk({tag, ".pc"},   a.pc,   e.pc);
    chk({tag, ".dest"}, a.dest, e.dest);
    chk({tag, ".src1"}, a.src1, e.src1);
    chk({tag, ".src2"}, a.src2, e.src2);
    chk({tag, ".wb"},   a.wb,   e.wb);
    chk({tag, ".mem"},  a.mem,  e.mem);
    chk({tag, ".br"},   a.br,   e.br);
    chk({tag, ".cmd"},  a.cmd,  e.cmd);
  endtask

  function automatic logic [31:0] mk_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference opcode table: wb, mem{rd,wr}, br, cmd, immediate form, sources read.
  typedef struct {
    logic [5:0] op;
    logic       wb;
    logic [1:0] mem, br;
    logic [3:0] cmd;
    logic       imm, u1, u2;
  } dec_row_t;

  dec_row_t dtab[17];

  function automatic dec_row_t lookup(logic [5:0] op);
    dec_row_t r = '{OpNop, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0};
    foreach (dtab[i]) if (dtab[i].op == op) r = dtab[i];
    return r;
  endfunction

  logic [31:0] m_rf [32];
  out_t        m_q1, m_q0, nx1, nx0;

  function automatic logic [31:0] m_read(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en_wb && dest_wb == idx) return result_wb;
    return m_rf[idx];
  endfunction

  function automatic logic m_stall(bit fwd);
    dec_row_t   r  = lookup(instruction[31:26]);
    logic [4:0] s[2];
    logic       u[2];
    logic       st = 1'b0;
    s[0] = instruction[25:21]; u[0] = r.u1;
    s[1] = instruction[20:16]; u[1] = r.u2;
    for (int k = 0; k < 2; k++) begin
      if (u[k] && s[k] != 5'd0) begin
        if (fwd) st |= exe_wb_en && exe_mem_rd && exe_dest == s[k];
        else     st |= (exe_wb_en && exe_dest == s[k]) || (mem_wb_en && mem_dest == s[k]);
      end
    end
    return st && !flush;
  endfunction

  function automatic out_t m_decode();
    dec_row_t          r = lookup(instruction[31:26]);
    logic signed [15:0] simm = instruction[15:0];
    out_t              o;
    o.val1 = m_read(instruction[25:21]);
    o.reg2 = m_read(instruction[20:16]);
    o.val2 = r.imm ? 32'(simm) : o.reg2;
    o.pc   = pc_in;
    o.dest = r.imm ? instruction[20:16] : instruction[15:11];
    o.src1 = instruction[25:21];
    o.src2 = instruction[20:16];
    o.wb   = r.wb;
    o.mem  = r.mem;
    o.br   = r.br;
    o.cmd  = r.cmd;
    return o;
  endfunction

  function automatic out_t m_next(bit fwd, out_t cur);
    if (freeze) return cur;
    if (flush || m_stall(fwd)) return '0;
    return m_decode();
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        ewb, erd;
    logic [4:0]  edst;
    logic        mwb;
    logic [4:0]  mdst;
    logic        fl, s1, s0;
  } hz_vec_t;

  hz_vec_t hv[18];

  logic [5:0] ops[18];

  task automatic idle();
    flush = 0; freeze = 0; instruction = '0; pc_in = '0;
    wb_en_wb = 0; dest_wb = '0; result_wb = '0;
    exe_wb_en = 0; exe_mem_rd = 0; exe_dest = '0; mem_wb_en = 0; mem_dest = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dtab[0]  = '{OpAdd,  1, 2'b00, 2'b00, 4'b0000, 0, 1, 1};
    dtab[1]  = '{OpSub,  1, 2'b00, 2'b00, 4'b0010, 0, 1, 1};
    dtab[2]  = '{OpAnd,  1, 2'b00, 2'b00, 4'b0100, 0, 1, 1};
    dtab[3]  = '{OpOr,   1, 2'b00, 2'b00, 4'b0101, 0, 1, 1};
    dtab[4]  = '{OpNor,  1, 2'b00, 2'b00, 4'b0110, 0, 1, 1};
    dtab[5]  = '{OpXor,  1, 2'b00, 2'b00, 4'b0111, 0, 1, 1};
    dtab[6]  = '{OpSla,  1, 2'b00, 2'b00, 4'b1000, 0, 1, 1};
    dtab[7]  = '{OpSll,  1, 2'b00, 2'b00, 4'b1000, 0, 1, 1};
    dtab[8]  = '{OpSra,  1, 2'b00, 2'b00, 4'b1001, 0, 1, 1};
    dtab[9]  = '{OpSrl,  1, 2'b00, 2'b00, 4'b1010, 0, 1, 1};
    dtab[10] = '{OpAddi, 1, 2'b00, 2'b00, 4'b0000, 1, 1, 0};
    dtab[11] = '{OpSubi, 1, 2'b00, 2'b00, 4'b0010, 1, 1, 0};
    dtab[12] = '{OpLd,   1, 2'b10, 2'b00, 4'b0000, 1, 1, 0};
    dtab[13] = '{OpSt,   0, 2'b01, 2'b00, 4'b0000, 1, 1, 1};
    dtab[14] = '{OpBez,  0, 2'b00, 2'b01, 4'b0000, 1, 1, 0};
    dtab[15] = '{OpBne,  0, 2'b00, 2'b10, 4'b0000, 1, 1, 1};
    dtab[16] = '{OpJmp,  0, 2'b00, 2'b11, 4'b0000, 1, 0, 0};

    ops = '{OpNop, OpAdd, OpSub, OpAnd, OpOr, OpNor, OpXor, OpSla, OpSll, OpSra, OpSrl,
            OpAddi, OpSubi, OpLd, OpSt, OpBez, OpBne, OpJmp};

    // instr, exe_wb_en, exe_mem_rd, exe_dest, mem_wb_en, mem_dest, flush, stall@fwd1, stall@fwd0
    hv[0]  = '{mk_r(OpAdd, 2, 3, 1),      1, 1, 5'd2, 0, 5'd0, 0, 1, 1};
    hv[1]  = '{mk_r(OpAdd, 2, 3, 1),      1, 0, 5'd2, 0, 5'd0, 0, 0, 1};
    hv[2]  = '{mk_r(OpAdd, 2, 3, 1),      1, 1, 5'd3, 0, 5'd0, 0, 1, 1};
    hv[3]  = '{mk_i(OpAddi, 2, 3, 16'h10), 1, 1, 5'd3, 0, 5'd0, 0, 0, 0};
    hv[4]  = '{mk_i(OpSt, 2, 3, 16'h4),   1, 1, 5'd3, 0, 5'd0, 0, 1, 1};
    hv[5]  = '{mk_i(OpBne, 4, 5, 16'h8),  0, 0, 5'd0, 1, 5'd5, 0, 0, 1};
    hv[6]  = '{mk_i(OpBez, 4, 5, 16'h8),  0, 0, 5'd0, 1, 5'd5, 0, 0, 0};
    hv[7]  = '{mk_i(OpJmp, 4, 5, 16'h8),  1, 1, 5'd4, 1, 5'd4, 0, 0, 0};
    hv[8]  = '{mk_i(6'h3F, 4, 5, 16'h0),  1, 1, 5'd4, 1, 5'd5, 0, 0, 0};
    hv[9]  = '{mk_r(OpAdd, 0, 0, 1),      1, 1, 5'd0, 1, 5'd0, 0, 0, 0};
    hv[10] = '{mk_r(OpSub, 2, 1, 7),      1, 1, 5'd2, 1, 5'd1, 1, 0, 0};
    hv[11] = '{mk_r(OpAdd, 1, 2, 3),      0, 1, 5'd1, 0, 5'd0, 0, 0, 0};
    hv[12] = '{mk_r(OpAdd, 1, 2, 3),      0, 0, 5'd0, 1, 5'd1, 0, 0, 1};
    hv[13] = '{mk_r(OpAdd, 1, 2, 3),      0, 0, 5'd0, 1, 5'd0, 0, 0, 0};
    hv[14] = '{mk_i(OpLd, 6, 7, 16'h0),   1, 1, 5'd6, 0, 5'd0, 0, 1, 1};
    hv[15] = '{mk_i(OpLd, 6, 7, 16'h0),   1, 1, 5'd7, 0, 5'd0, 0, 0, 0};
    hv[16] = '{mk_r(OpSrl, 3, 9, 1),      1, 0, 5'd9, 0, 5'd0, 0, 0, 1};
    hv[17] = '{mk_i(OpSubi, 9, 3, 16'h1), 0, 0, 5'd0, 1, 5'd9, 0, 0, 1};

    // Reset with busy-looking inputs; the WB write must not land.
    idle();
    rst = 1; instruction = mk_i(OpAddi, 1, 3, 16'h1234); pc_in = 32'h40;
    wb_en_wb = 1; dest_wb = 5'd5; result_wb = 32'hDEAD;
    #2;
    chk("rst.stall1", o1_hazard, 1'b0);
    chk("rst.stall0", o0_hazard, 1'b0);
    tick();
    chk_out("rst1", act1, '0);
    chk_out("rst0", act0, '0);
    rst = 0; idle(); instruction = mk_r(OpAdd, 5, 0, 9);
    tick();
    chk("rst.r5", o1_val1, 32'd0);
    chk("rst.dest", o1_dest, 5'd9);

    // ADDI r3,r1,-2 with r1 = 7
    idle(); wb_en_wb = 1; dest_wb = 5'd1; result_wb = 32'd7;
    tick();
    idle(); instruction = mk_i(OpAddi, 1, 3, 16'hFFFE); pc_in = 32'h104;
    tick();
    chk("addi.val1", o1_val1, 32'd7);
    chk("addi.val2", o1_val2, 32'hFFFFFFFE);
    chk("addi.dest", o1_dest, 5'd3);
    chk("addi.cmd",  o1_cmd, 4'b0000);
    chk("addi.wb",   o1_wb, 1'b1);
    chk("addi.pc",   o1_pc, 32'h104);
    chk("addi.src1", o1_src1, 5'd1);
    chk("addi.val2_0", o0_val2, 32'hFFFFFFFE);

    // Write-through
    idle(); instruction = mk_r(OpAdd, 4, 4, 6); wb_en_wb = 1; dest_wb = 5'd4; result_wb = 32'h55;
    tick();
    chk("wt.val1", o1_val1, 32'h55);
    chk("wt.val2", o1_val2, 32'h55);
    chk("wt.dest", o1_dest, 5'd6);

    // Load-use: one bubble, then the SUB issues
    idle(); instruction = mk_r(OpSub, 2, 1, 7); exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 5'd2;
    #1;
    chk("lu.stall", o1_hazard, 1'b1);
    tick();
    chk("lu.bubble_wb",  o1_wb, 1'b0);
    chk("lu.bubble_cmd", o1_cmd, 4'b0000);
    exe_wb_en = 0; exe_mem_rd = 0; mem_wb_en = 1; mem_dest = 5'd2;
    #1;
    chk("lu.clear1", o1_hazard, 1'b0);
    chk("lu.memraw0", o0_hazard, 1'b1);
    tick();
    chk("lu.issue_wb",   o1_wb, 1'b1);
    chk("lu.issue_cmd",  o1_cmd, 4'b0010);
    chk("lu.issue_dest", o1_dest, 5'd7);
    chk("lu.issue_val2", o1_val2, 32'd7);

    // Hazard table (combinational)
    for (int i = 0; i < 18; i++) begin
      idle();
      instruction = hv[i].instr; exe_wb_en = hv[i].ewb; exe_mem_rd = hv[i].erd;
      exe_dest = hv[i].edst; mem_wb_en = hv[i].mwb; mem_dest = hv[i].mdst; flush = hv[i].fl;
      #1;
      chk($sformatf("hz%0d.fwd1", i), o1_hazard, hv[i].s1);
      chk($sformatf("hz%0d.fwd0", i), o0_hazard, hv[i].s0);
    end

    // Flush wins over a hazard
    @(negedge clk);
    idle(); instruction = mk_r(OpSub, 2, 1, 7); exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 5'd2;
    flush = 1;
    #1;
    chk("fl.stall1", o1_hazard, 1'b0);
    chk("fl.stall0", o0_hazard, 1'b0);
    tick();
    chk("fl.wb1", o1_wb, 1'b0);
    chk("fl.wb0", o0_wb, 1'b0);

    // Freeze holds over flush and over a stall
    idle(); instruction = mk_i(OpAddi, 1, 3, 16'd5); pc_in = 32'h100;
    tick();
    chk("fz.load_val2", o1_val2, 32'd5);
    idle(); freeze = 1; flush = 1; instruction = mk_r(OpAdd, 4, 4, 6); pc_in = 32'h200;
    tick();
    chk("fz.val1", o1_val1, 32'd7);
    chk("fz.val2", o1_val2, 32'd5);
    chk("fz.pc",   o1_pc, 32'h100);
    chk("fz.dest", o1_dest, 5'd3);
    chk("fz.wb",   o1_wb, 1'b1);
    flush = 0; exe_wb_en = 1; exe_mem_rd = 1; exe_dest = 5'd4;
    tick();
    chk("fz2.pc", o1_pc, 32'h100);
    chk("fz2.wb", o1_wb, 1'b1);
    chk("fz2.wb0", o0_wb, 1'b1);

    // Randomized run against the model
    @(negedge clk);
    idle(); rst = 1;
    tick();
    rst = 0;
    foreach (m_rf[i]) m_rf[i] = '0;
    m_q1 = '0; m_q0 = '0;
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int unsigned sel;
      @(negedge clk);
      sel = $urandom_range(0, 19);
      op  = (sel < 18) ? ops[sel] : 6'($urandom_range(0, 63));
      instruction = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 11'($urandom)};
      pc_in      = $urandom;
      wb_en_wb   = 1'($urandom_range(0, 1));
      dest_wb    = 5'($urandom_range(0, 7));
      result_wb  = $urandom;
      exe_wb_en  = 1'($urandom_range(0, 1));
      exe_mem_rd = 1'($urandom_range(0, 1));
      exe_dest   = 5'($urandom_range(0, 7));
      mem_wb_en  = 1'($urandom_range(0, 1));
      mem_dest   = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 7) == 0);
      freeze     = ($urandom_range(0, 7) == 0);
      #1;
      chk("rnd.stall1", o1_hazard, m_stall(1'b1));
      chk("rnd.stall0", o0_hazard, m_stall(1'b0));
      nx1 = m_next(1'b1, m_q1);
      nx0 = m_next(1'b0, m_q0);
      @(posedge clk);
      m_q1 = nx1;
      m_q0 = nx0;
      if (wb_en_wb && dest_wb != 5'd0) m_rf[dest_wb] = result_wb;
      #1;
      chk_out("rnd1", act1, m_q1);
      chk_out("rnd0", act0, m_q0);
    end

    // Reset mid-cycle clears immediately, including the register file
    @(negedge clk);
    idle(); wb_en_wb = 1; dest_wb = 5'd1; result_wb = 32'hABCD1234;
    instruction = mk_r(OpAdd, 1, 1, 2);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk_out("arst1", act1, '0);
    chk_out("arst0", act0, '0);
    @(negedge clk);
    rst = 0; idle(); instruction = mk_r(OpAdd, 1, 1, 2);
    tick();
    chk("arst.r1", o1_val1, 32'd0);
    chk("arst.wb", o1_wb, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
